alu_result_checker: RTL and testbench

// - Observes the ALU interface (a, b, aluc, r, z) and checks each sampled result against an internal reference model.
// - It is the receiving/checking end of the interface that the ALU stimulus side drives.
// - Used for on-board ALU self-test and as a synthesizable scoreboard in the CPU datapath benches.
// - Counts passes and failures, and latches the first failing transaction.

---
 rtl/alu_defs_pkg.sv | 21 ++
 rtl/alu_ref_model.sv | 33 +++
 rtl/alu_result_checker.sv | 112 +++++++++++
 tb/tb_alu_result_checker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: opcode constants and checker state encodings.
// Used by the ALU, the stimulus generators and the result checker.
package alu_defs_pkg;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FAIL = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational ALU reference: (a, b, aluc) -> expected result and zero flag.
module alu_ref_model
  import alu_defs_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  aluc,
  output logic [31:0] exp_r,
  output logic        exp_z
);

  logic [4:0] sh;
  assign sh = a[4:0];

  // Only aluc[2:0] selects the op; aluc[3] only splits SRL from SRA.
  always_comb begin
    exp_r = '0;
    case (aluc[2:0])
      ALUC_ADD[2:0]: exp_r = a + b;
      ALUC_SUB[2:0]: exp_r = a - b;
      ALUC_AND[2:0]: exp_r = a & b;
      ALUC_OR[2:0]:  exp_r = a | b;
      ALUC_XOR[2:0]: exp_r = a ^ b;
      ALUC_LUI[2:0]: exp_r = {b[15:0], 16'h0000};
      ALUC_SLL[2:0]: exp_r = b << sh;
      ALUC_SRL[2:0]: exp_r = aluc[3] ? 32'($signed(b) >>> sh) : (b >> sh);
      default:       exp_r = '0;
    endcase
  end

  assign exp_z = (exp_r == 32'h0);

endmodule

// File: rtl/alu_result_checker.sv
// Two-stage ALU result checker: sample, compare against alu_ref_model, count,
// and capture the first failing transaction.
module alu_result_checker
  import alu_defs_pkg::*;
#(
  parameter int unsigned CNT_W        = 16,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  input  logic [3:0]       aluc,
  input  logic [31:0]      r,
  input  logic             z,
  output logic             chk_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [1:0]       state,
  output logic             ff_valid,
  output logic [3:0]       ff_aluc,
  output logic [31:0]      ff_exp,
  output logic [31:0]      ff_got
);

  logic             s1_valid_q;
  logic [31:0]      s1_a_q, s1_b_q, s1_r_q;
  logic [3:0]       s1_aluc_q;
  logic             s1_z_q;
  logic             chk_valid_q, mismatch_q;
  logic [CNT_W-1:0] pass_q, fail_q;
  state_e           state_q;
  logic             ff_valid_q;
  logic [3:0]       ff_aluc_q;
  logic [31:0]      ff_exp_q, ff_got_q;

  logic [31:0] exp_r;
  logic        exp_z;
  logic        halted, accept, check, bad;

  alu_ref_model u_ref (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .aluc (s1_aluc_q),
    .exp_r(exp_r),
    .exp_z(exp_z)
  );

  // A halted checker drops both new samples and the one already in stage 1.
  assign halted = STOP_ON_FAIL && (state_q == ST_FAIL);
  assign accept = in_valid && !halted;
  assign check  = s1_valid_q && !halted;
  assign bad    = check && ((s1_r_q != exp_r) || (s1_z_q != exp_z));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_r_q      <= '0;
      s1_aluc_q   <= '0;
      s1_z_q      <= 1'b0;
      chk_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
      state_q     <= ST_IDLE;
      ff_valid_q  <= 1'b0;
      ff_aluc_q   <= '0;
      ff_exp_q    <= '0;
      ff_got_q    <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q    <= a;
        s1_b_q    <= b;
        s1_r_q    <= r;
        s1_aluc_q <= aluc;
        s1_z_q    <= z;
      end
      chk_valid_q <= check;
      mismatch_q  <= bad;
      if (check && !bad && (pass_q != '1)) pass_q <= pass_q + 1'b1;
      if (bad && (fail_q != '1))           fail_q <= fail_q + 1'b1;
      if (bad) begin
        state_q <= ST_FAIL;
      end else if (accept && (state_q == ST_IDLE)) begin
        state_q <= ST_RUN;
      end
      if (bad && !ff_valid_q) begin
        ff_valid_q <= 1'b1;
        ff_aluc_q  <= s1_aluc_q;
        ff_exp_q   <= exp_r;
        ff_got_q   <= s1_r_q;
      end
    end
  end

  assign chk_valid = chk_valid_q;
  assign mismatch  = mismatch_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign state     = state_q;
  assign ff_valid  = ff_valid_q;
  assign ff_aluc   = ff_aluc_q;
  assign ff_exp    = ff_exp_q;
  assign ff_got    = ff_got_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: three instances (keep-checking, stop-on-fail,
// 2-bit counters) share one stimulus stream and are compared to a scoreboard.
module tb_alu_result_checker;
  import alu_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, z;
  logic [31:0] a, b, r;
  logic [3:0]  aluc;

  logic        cv0, mm0, ffv0, cv1, mm1, ffv1, cv2, mm2, ffv2;
  logic [1:0]  st0, st1, st2;
  logic [15:0] pc0, fc0, pc1, fc1;
  logic [1:0]  pc2, fc2;
  logic [3:0]  ffa0, ffa1, ffa2;
  logic [31:0] ffe0, ffe1, ffe2, ffg0, ffg1, ffg2;

  int errors = 0;
  int checks = 0;
  int e      = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .a(a), .b(b), .aluc(aluc),
    .r(r), .z(z), .chk_valid(cv0), .mismatch(mm0), .pass_cnt(pc0), .fail_cnt(fc0),
    .state(st0), .ff_valid(ffv0), .ff_aluc(ffa0), .ff_exp(ffe0), .ff_got(ffg0)
  );

  alu_result_checker #(.CNT_W(16), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .a(a), .b(b), .aluc(aluc),
    .r(r), .z(z), .chk_valid(cv1), .mismatch(mm1), .pass_cnt(pc1), .fail_cnt(fc1),
    .state(st1), .ff_valid(ffv1), .ff_aluc(ffa1), .ff_exp(ffe1), .ff_got(ffg1)
  );

  alu_result_checker #(.CNT_W(2), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .a(a), .b(b), .aluc(aluc),
    .r(r), .z(z), .chk_valid(cv2), .mismatch(mm2), .pass_cnt(pc2), .fail_cnt(fc2),
    .state(st2), .ff_valid(ffv2), .ff_aluc(ffa2), .ff_exp(ffe2), .ff_got(ffg2)
  );

  // Scoreboard: each sample becomes a pending check due one edge after capture.
  typedef struct packed {
    int          due;
    logic        mm;
    logic [2:0]  acc;
    logic [3:0]  aluc;
    logic [31:0] er;
    logic [31:0] gr;
  } txn_t;

  txn_t        pend[$];
  logic        m_chk[3], m_mm[3], m_ffv[3];
  logic [1:0]  m_st[3];
  int          m_pass[3], m_fail[3];
  logic [3:0]  m_ffa[3];
  logic [31:0] m_ffe[3], m_ffg[3];

  function automatic int stop_of(int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int max_of(int k);
    return (k == 2) ? 3 : 65535;
  endfunction

  function automatic logic [31:0] ref_r(logic [3:0] op, logic [31:0] x, logic [31:0] y);
    logic [63:0] ext;
    int sh;
    sh  = int'(x % 32);
    ext = {{32{y[31]}}, y};
    case (op[2:0])
      3'b000:  return x + y;
      3'b100:  return x - y;
      3'b001:  return x & y;
      3'b101:  return x | y;
      3'b010:  return x ^ y;
      3'b110:  return y * 32'h10000;
      3'b011:  return y << sh;
      default: begin
        if (op[3]) begin
          ext = ext >> sh;
          return ext[31:0];
        end
        return y >> sh;
      end
    endcase
  endfunction

  task automatic model_edge();
    txn_t t;
    logic have;
    logic [2:0] halt;
    for (int k = 0; k < 3; k++) begin
      halt[k]  = (stop_of(k) == 1) && (m_st[k] == ST_FAIL);
      m_chk[k] = 1'b0;
      m_mm[k]  = 1'b0;
    end
    if (rst || clr) begin
      pend.delete();
      for (int k = 0; k < 3; k++) begin
        m_pass[k] = 0;  m_fail[k] = 0;  m_st[k] = ST_IDLE;
        m_ffv[k]  = 0;  m_ffa[k]  = '0; m_ffe[k] = '0;  m_ffg[k] = '0;
      end
    end else begin
      have = 1'b0;
      t    = '0;
      if (pend.size() > 0 && pend[0].due == e) begin
        t    = pend.pop_front();
        have = 1'b1;
      end
      for (int k = 0; k < 3; k++) begin
        if (have && t.acc[k] && !halt[k]) begin
          m_chk[k] = 1'b1;
          m_mm[k]  = t.mm;
          if (t.mm) begin
            if (m_fail[k] < max_of(k)) m_fail[k]++;
            m_st[k] = ST_FAIL;
            if (!m_ffv[k]) begin
              m_ffv[k] = 1'b1; m_ffa[k] = t.aluc; m_ffe[k] = t.er; m_ffg[k] = t.gr;
            end
          end else if (m_pass[k] < max_of(k)) begin
            m_pass[k]++;
          end
        end
      end
      if (in_valid) begin
        t.due  = e + 1;
        t.er   = ref_r(aluc, a, b);
        t.gr   = r;
        t.aluc = aluc;
        t.mm   = (r !== t.er) || (z !== (t.er == 32'h0));
        t.acc  = ~halt;
        pend.push_back(t);
        for (int k = 0; k < 3; k++)
          if (!halt[k] && m_st[k] == ST_IDLE) m_st[k] = ST_RUN;
      end
    end
    e++;
  endtask

  task automatic chk(int k, string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL u%0d.%s edge=%0d observed=%h expected=%h", k, tag, e, got, exp);
    end
  endtask

  task automatic check_inst(int k, logic cvv, logic mmv, logic [1:0] stv, logic [15:0] pcv,
                            logic [15:0] fcv, logic ffvv, logic [3:0] ffav,
                            logic [31:0] ffev, logic [31:0] ffgv);
    chk(k, "chk_valid", 32'(cvv), 32'(m_chk[k]));
    chk(k, "mismatch", 32'(mmv), 32'(m_mm[k]));
    chk(k, "state", 32'(stv), 32'(m_st[k]));
    chk(k, "pass_cnt", 32'(pcv), 32'(m_pass[k]));
    chk(k, "fail_cnt", 32'(fcv), 32'(m_fail[k]));
    chk(k, "ff_valid", 32'(ffvv), 32'(m_ffv[k]));
    chk(k, "ff_aluc", 32'(ffav), 32'(m_ffa[k]));
    chk(k, "ff_exp", ffev, m_ffe[k]);
    chk(k, "ff_got", ffgv, m_ffg[k]);
  endtask

  task automatic check_all();
    check_inst(0, cv0, mm0, st0, pc0, fc0, ffv0, ffa0, ffe0, ffg0);
    check_inst(1, cv1, mm1, st1, pc1, fc1, ffv1, ffa1, ffe1, ffg1);
    check_inst(2, cv2, mm2, st2, {14'b0, pc2}, {14'b0, fc2}, ffv2, ffa2, ffe2, ffg2);
  endtask

  task automatic drive(logic v, logic [3:0] op, logic [31:0] aa, logic [31:0] bb,
                       logic [31:0] rr, logic zz, logic cc, logic rs);
    in_valid = v; aluc = op; a = aa; b = bb; r = rr; z = zz; clr = cc; rst = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go(logic [3:0] op, logic [31:0] aa, logic [31:0] bb);
    logic [31:0] rr;
    rr = ref_r(op, aa, bb);
    drive(1'b1, op, aa, bb, rr, rr == 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra, rb, rr;
    logic [3:0]  rop;
    logic        rz;
    for (int k = 0; k < 3; k++) begin
      m_pass[k] = 0; m_fail[k] = 0; m_st[k] = ST_IDLE; m_chk[k] = 0; m_mm[k] = 0;
      m_ffv[k]  = 0; m_ffa[k]  = '0; m_ffe[k] = '0; m_ffg[k] = '0;
    end
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, ALUC_ADD, 32'd7, 32'd9, 32'd1, 1'b0, 1'b0, 1'b1);

    // T1
    drive(1'b1, ALUC_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk(0, "t1_chk_valid", 32'(cv0), 32'd1);
    chk(0, "t1_pass", 32'(pc0), 32'd1);
    chk(0, "t1_state", 32'(st0), 32'(ST_RUN));

    // T2: back-to-back, expected values written out literally
    drive(1'b1, ALUC_SUB, 32'h1, 32'h2, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ALUC_AND, 32'hCCCCCCCC, 32'hAAAAAAAA, 32'h88888888, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ALUC_OR,  32'hCCCCCCCC, 32'hAAAAAAAA, 32'hEEEEEEEE, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ALUC_XOR, 32'h33333333, 32'hFF005555, 32'hCC336666, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ALUC_LUI, 32'h33333333, 32'hFF005555, 32'h55550000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ALUC_SLL, 32'hF, 32'hFFFFFFFF, 32'hFFFF8000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ALUC_SRL, 32'hF, 32'hFFFFFFFF, 32'h0001FFFF, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ALUC_SRA, 32'h10, 32'h7F000000, 32'h00007F00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, ALUC_SRA, 32'h10, 32'hFFFFFF00, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk(0, "t2_fail", 32'(fc0), 32'd0);
    chk(0, "t2_pass", 32'(pc0), 32'd10);
    chk(2, "t7_pass_sat", 32'(pc2), 32'd3);

    // T3: bad SUB then three good ops
    drive(1'b1, ALUC_SUB, 32'd1, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0);
    go(ALUC_ADD, 32'd4, 32'd5);
    go(ALUC_OR, 32'h10, 32'h01);
    go(ALUC_XOR, 32'hF0, 32'h0F);
    idle(3);
    chk(1, "t3_state", 32'(st1), 32'(ST_FAIL));
    chk(1, "t3_ff_aluc", 32'(ffa1), 32'b0100);
    chk(1, "t3_ff_exp", ffe1, 32'hFFFFFFFF);
    chk(1, "t3_ff_got", ffg1, 32'h0);
    chk(1, "t3_fail", 32'(fc1), 32'd1);

    // T4: second mismatch keeps the first capture
    drive(1'b1, ALUC_ADD, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    chk(0, "t4_fail", 32'(fc0), 32'd2);
    chk(0, "t4_ff_aluc", 32'(ffa0), 32'b0100);
    chk(0, "t4_ff_got", ffg0, 32'h0);

    // T5: r right, z wrong
    drive(1'b1, ALUC_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1);
    chk(0, "t5_mismatch", 32'(mm0), 32'd1);
    idle(1);

    // T6: clr with checks in flight, sample alongside clr dropped
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    go(ALUC_ADD, 32'd1, 32'd1);
    go(ALUC_SUB, 32'd9, 32'd3);
    drive(1'b1, ALUC_ADD, 32'd2, 32'd2, 32'd0, 1'b1, 1'b1, 1'b0);
    idle(3);
    chk(0, "t6_pass", 32'(pc0), 32'd0);
    chk(0, "t6_state", 32'(st0), 32'(ST_IDLE));

    // Random stream with a mid-stream clr and rst
    for (int i = 0; i < 200; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rb  = $urandom;
      rr  = ref_r(rop, ra, rb);
      rz  = (rr == 32'h0);
      if ($urandom_range(0, 9) == 0) rr = rr ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) rz = ~rz;
      drive($urandom_range(0, 3) != 0, rop, ra, rb, rr, rz, i == 70, i == 140);
      if (i == 140) chk(0, "rst_state", 32'(st0), 32'(ST_IDLE));
    end
    idle(2);

    // T7 from a clean start
    drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) go(ALUC_XOR, 32'(i), 32'h5A5A0000);
    idle(2);
    chk(2, "t7_pass_cnt", 32'(pc2), 32'd3);
    chk(0, "t7_pass_wide", 32'(pc0), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
